wb_arbiter2: RTL and testbench

//  Two-master to one-slave Wishbone B4 classic arbiter; shares the SoC bus (wb_mux input) between
//  the CPU (m0) and a second initiator (m1: debug/DMA). Round-robin grant, locked for the whole

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_arb_rr_pick.sv | 21 ++
 rtl/wb_arbiter2.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter2.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone B4 classic arbiter.
// Included by wb_arb_rr_pick and wb_arbiter2.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Stall-counter width; never narrower than one bit.
  function automatic int timeout_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational two-way round-robin chooser: a lone request wins outright,
// a tie goes to the master that did not own the bus last.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_M0;
      2'b10:   gnt = GNT_M1;
      2'b11:   gnt = last ? GNT_M0 : GNT_M1;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone B4 classic arbiter, round-robin, grant locked for a whole cyc.
// Optional stb-without-ack bus timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic                     m0_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_cyc_i,
  output logic                     m0_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,
  output logic                     m0_err_o,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic                     m1_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_cyc_i,
  output logic                     m1_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,
  output logic                     m1_err_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic                     s_we_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_stb_o,
  output logic                     s_cyc_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i,
  output logic [1:0]               gnt_o
);

  localparam int TO_W = timeout_width(TIMEOUT_CYCLES);

  arb_state_t               state, state_nxt;
  logic [1:0]               gnt, gnt_nxt, pick;
  logic                     last, last_nxt;
  logic                     own_cyc, own_stb, own_we;
  logic [WB_ADDR_WIDTH-1:0] own_addr;
  logic [WB_DATA_WIDTH-1:0] own_data;
  logic [WB_SEL_WIDTH-1:0]  own_sel;
  logic                     bus_on;
  logic                     timeout_hit;

  wb_arb_rr_pick u_pick (
    .req  ({m1_cyc_i, m0_cyc_i}),
    .last (last),
    .gnt  (pick)
  );

  // Owner's signals selected by the registered grant; all zero while idle.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_sel  = '0;
    if (gnt == GNT_M0) begin
      own_cyc  = m0_cyc_i;
      own_stb  = m0_stb_i;
      own_we   = m0_we_i;
      own_addr = m0_addr_i;
      own_data = m0_data_i;
      own_sel  = m0_sel_i;
    end else if (gnt == GNT_M1) begin
      own_cyc  = m1_cyc_i;
      own_stb  = m1_stb_i;
      own_we   = m1_we_i;
      own_addr = m1_addr_i;
      own_data = m1_data_i;
      own_sel  = m1_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt   <= GNT_NONE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_nxt = BUSY;
          gnt_nxt   = pick;
        end
      end
      BUSY, ABORT: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          gnt_nxt   = GNT_NONE;
          last_nxt  = gnt[1];
        end else if (state == BUSY && timeout_hit) begin
          state_nxt = ABORT;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = GNT_NONE;
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Counts stalled strobe cycles of the current owner; any ack or release restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != BUSY || !own_cyc || s_ack_i) begin
      to_cnt <= '0;
    end else if (own_stb) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == BUSY) && own_cyc && own_stb && !s_ack_i &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [TO_W-1:0] unused_to_cnt;
  assign unused_to_cnt = '0;
  assign timeout_hit   = 1'b0;
`endif

  assign bus_on = (state == BUSY) && !rst_i;

  assign s_cyc_o   = bus_on & own_cyc;
  assign s_stb_o   = bus_on & own_stb;
  assign s_we_o    = own_we;
  assign s_addr_o  = own_addr;
  assign s_data_o  = own_data;
  assign s_sel_o   = own_sel;
  assign m0_ack_o  = bus_on & gnt[0] & s_ack_i;
  assign m1_ack_o  = bus_on & gnt[1] & s_ack_i;
  assign m0_err_o  = timeout_hit & gnt[0] & !rst_i;
  assign m1_err_o  = timeout_hit & gnt[1] & !rst_i;
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign gnt_o     = gnt;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus a per-cycle reference model.
// Timeout scenario runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

  localparam int TB_TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  int testsRun = 0;
  int testsFailed = 0;

  wb_arbiter2 #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_data_i(s_data_i),
    .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: who owns the bus (-1 = nobody), who owned it last, abort and stall tracking.
  int   owner = -1;
  int   lastOwner = 1;
  int   stall = 0;
  logic aborted = 1'b0;
  logic modelValid = 1'b0;

  function automatic logic ownCyc();
    return (owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0;
  endfunction

  function automatic logic ownStb();
    return (owner == 0) ? m0_stb_i : (owner == 1) ? m1_stb_i : 1'b0;
  endfunction

  function automatic logic expErr();
`ifdef WB_ARB_TIMEOUT_EN
    return !rst_i && owner >= 0 && !aborted && ownCyc() && ownStb() && !s_ack_i &&
           stall == TB_TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      owner      <= -1;
      lastOwner  <= 1;
      aborted    <= 1'b0;
      stall      <= 0;
      modelValid <= 1'b1;
    end else if (owner < 0) begin
      stall <= 0;
      if (m0_cyc_i && m1_cyc_i) owner <= 1 - lastOwner;
      else if (m0_cyc_i)        owner <= 0;
      else if (m1_cyc_i)        owner <= 1;
    end else if (!ownCyc()) begin
      lastOwner <= owner;
      owner     <= -1;
      aborted   <= 1'b0;
      stall     <= 0;
    end else if (!aborted) begin
      if (expErr()) begin
        aborted <= 1'b1;
        stall   <= 0;
      end else if (s_ack_i) stall <= 0;
      else if (ownStb())    stall <= stall + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (modelValid) begin
      logic busOn, eCyc;
      logic [1:0] eGnt;
      busOn = !rst_i && owner >= 0 && !aborted;
      eCyc  = busOn && ownCyc();
      eGnt  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      checkOutput("mdl_s_cyc", s_cyc_o, eCyc);
      checkOutput("mdl_s_stb", s_stb_o, busOn && ownStb());
      checkOutput("mdl_m0_ack", m0_ack_o, busOn && owner == 0 && s_ack_i);
      checkOutput("mdl_m1_ack", m1_ack_o, busOn && owner == 1 && s_ack_i);
      checkOutput("mdl_gnt", gnt_o, eGnt);
      checkOutput("mdl_m0_err", m0_err_o, expErr() && owner == 0);
      checkOutput("mdl_m1_err", m1_err_o, expErr() && owner == 1);
      checkOutput("mdl_m0_rdata", m0_data_o, s_data_i);
      checkOutput("mdl_m1_rdata", m1_data_o, s_data_i);
      if (eCyc) begin
        checkOutput("mdl_s_addr", s_addr_o, owner == 0 ? m0_addr_i : m1_addr_i);
        checkOutput("mdl_s_wdata", s_data_o, owner == 0 ? m0_data_i : m1_data_i);
        checkOutput("mdl_s_we", s_we_o, owner == 0 ? m0_we_i : m1_we_i);
        checkOutput("mdl_s_sel", s_sel_o, owner == 0 ? m0_sel_i : m1_sel_i);
      end
    end
  end

  task automatic waitCycle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic c0, input logic s0, input logic c1, input logic s1,
                               input logic ack, input logic [31:0] rdata);
    m0_cyc_i = c0;
    m0_stb_i = s0;
    m1_cyc_i = c1;
    m1_stb_i = s1;
    s_ack_i  = ack;
    s_data_i = rdata;
    #1;
  endtask

  task automatic pulseReset();
    rst_i = 1'b1;
    waitCycle(1);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m0Acks, m1Acks;
    logic [1:0] expGnt;
    rst_i = 1'b1;
    m0_addr_i = 32'h0000_0100; m0_data_i = 32'h1111_1111; m0_we_i = 1'b0; m0_sel_i = 4'hF;
    m1_addr_i = 32'h0000_0200; m1_data_i = 32'h2222_2222; m1_we_i = 1'b1; m1_sel_i = 4'h3;
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    waitCycle(3);
    checkOutput("rst_gnt", gnt_o, 2'b00);
    checkOutput("rst_s_cyc", s_cyc_o, 1'b0);
    checkOutput("rst_s_addr", s_addr_o, 32'h0);
    checkOutput("rst_m0_ack", m0_ack_o, 1'b0);
    rst_i = 1'b0;

    // Single m0 read, slave acks two cycles into the transfer.
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    waitCycle(1);
    checkOutput("t1_gnt", gnt_o, 2'b01);
    checkOutput("t1_s_cyc", s_cyc_o, 1'b1);
    checkOutput("t1_s_addr", s_addr_o, 32'h0000_0100);
    waitCycle(1);
    applyStimulus(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("t1_m0_ack", m0_ack_o, 1'b1);
    checkOutput("t1_m0_data", m0_data_o, 32'hDEAD_BEEF);
    checkOutput("t1_m1_ack", m1_ack_o, 1'b0);
    checkOutput("t1_m0_err", m0_err_o, 1'b0);
    waitCycle(1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    waitCycle(2);

    // Simultaneous requests after reset: m0 first, one idle cycle, then m1.
    pulseReset();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    waitCycle(1);
    checkOutput("t2_first_gnt", gnt_o, 2'b01);
    applyStimulus(1, 1, 1, 1, 1, 32'hA5A5_0001);
    waitCycle(1);
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t2_drop_s_cyc", s_cyc_o, 1'b0);
    waitCycle(1);
    checkOutput("t2_idle_gnt", gnt_o, 2'b00);
    checkOutput("t2_idle_s_cyc", s_cyc_o, 1'b0);
    waitCycle(1);
    checkOutput("t2_second_gnt", gnt_o, 2'b10);
    checkOutput("t2_m1_we", s_we_o, 1'b1);
    applyStimulus(0, 0, 1, 1, 1, 32'hA5A5_0002);
    waitCycle(1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    waitCycle(2);

    // m1 four-beat burst; m0 requests mid-burst and must stall.
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    waitCycle(1);
    m0Acks = 0;
    m1Acks = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i >= 1, i >= 1, 1, 1, 1, 32'hB000_0000 + i);
      if (m0_ack_o) m0Acks++;
      if (m1_ack_o) m1Acks++;
      checkOutput("t3_burst_gnt", gnt_o, 2'b10);
      waitCycle(1);
    end
    checkOutput("t3_m1_ack_count", m1Acks, 4);
    checkOutput("t3_m0_ack_count", m0Acks, 0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    waitCycle(1);
    checkOutput("t3_idle_gnt", gnt_o, 2'b00);
    waitCycle(1);
    checkOutput("t3_m0_after", gnt_o, 2'b01);
    applyStimulus(1, 1, 0, 0, 1, 32'hC0DE_0000);
    waitCycle(1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    waitCycle(2);

    // Continuous contention: grants alternate 01,10,01,...
    pulseReset();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 6 && gnt_o == 2'b00; w++) waitCycle(1);
      expGnt = (t % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput("t4_gnt_seq", gnt_o, expGnt);
      applyStimulus(1, 1, 1, 1, 1, 32'h4000_0000 + t);
      waitCycle(1);
      if (gnt_o == 2'b01) applyStimulus(0, 0, 1, 1, 0, 32'h0);
      else                applyStimulus(1, 1, 0, 0, 0, 32'h0);
      waitCycle(1);
      applyStimulus(1, 1, 1, 1, 0, 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    waitCycle(3);

    // Reset while m1 owns the bus mid-strobe.
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    waitCycle(1);
    checkOutput("t5_pre_gnt", gnt_o, 2'b10);
    rst_i = 1'b1;
    applyStimulus(0, 0, 1, 1, 1, 32'h5555_5555);
    checkOutput("t5_rst_s_cyc", s_cyc_o, 1'b0);
    checkOutput("t5_rst_s_stb", s_stb_o, 1'b0);
    checkOutput("t5_rst_m1_ack", m1_ack_o, 1'b0);
    waitCycle(1);
    rst_i = 1'b0;
    checkOutput("t5_post_gnt", gnt_o, 2'b00);
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    waitCycle(1);
    checkOutput("t5_tie_to_m0", gnt_o, 2'b01);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    waitCycle(3);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: error on the eighth stalled strobe, then abort until m0 lets go.
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    waitCycle(1);
    for (int i = 1; i <= TB_TO; i++) begin
      checkOutput("t6_err_pulse", m0_err_o, i == TB_TO);
      if (i < TB_TO) waitCycle(1);
    end
    waitCycle(1);
    checkOutput("t6_abort_s_cyc", s_cyc_o, 1'b0);
    checkOutput("t6_abort_err", m0_err_o, 1'b0);
    waitCycle(2);
    checkOutput("t6_abort_hold", s_cyc_o, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    waitCycle(2);
    checkOutput("t6_idle_gnt", gnt_o, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
